// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
//
// Holds the fetch PC, issues single-outstanding read requests to instruction
// memory over a req/ack handshake and buffers returned words in a 2-entry
// FIFO of {pc, word}. While the FIFO is empty the decoder sees NOP_INSN.
//
// Parameters:
//   RESET_PC     fetch address after reset
//   NOP_INSN     word presented while nothing is buffered
//
// Ports:
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   imem_req     read request, held until imem_ack
//   imem_addr    word address, stable while imem_req is high
//   imem_ack     one-cycle response strobe per request
//   imem_rdata   instruction word, valid with imem_ack
//   stall        decoder holding the current instruction (no pop)
//   redirect     one-cycle pulse: discard buffered and in-flight fetches
//   redirect_pc  new fetch PC (bits [1:0] ignored)
//   instruction  FIFO head, or NOP_INSN when empty
//   inst_pc      PC of the head, or fetch_pc when empty
//   inst_valid   head holds a real instruction
//
// Build option:
//   FETCH_BYPASS_EN  when defined, an ack arriving with the FIFO empty is
//                    presented to the decoder in the same cycle (and only
//                    pushed if the decoder stalls).

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instruction,
    output logic [31:0] inst_pc,
    output logic        inst_valid
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] fifo_pc   [2];
    logic [31:0] fifo_word [2];
    logic [1:0]  count;
    logic [1:0]  count_after;
    logic        ack_live;
    logic        bypass_take;
    logic        push;
    logic        fifo_pop;
    logic [31:0] redirect_aligned;

    assign imem_req         = (state != IDLE);
    assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;

    always_comb begin
        // A usable response: the request is live and not being discarded.
        ack_live = (state == WAIT) && imem_ack && !redirect;
`ifdef FETCH_BYPASS_EN
        bypass_take = ack_live && (count == 2'd0) && !stall;
`else
        bypass_take = 1'b0;
`endif
        push        = ack_live && !bypass_take;
        fifo_pop    = (count != 2'd0) && !stall && !redirect;
        count_after = count + {1'b0, push} - {1'b0, fifo_pop};
    end

    always_comb begin
        inst_valid  = 1'b0;
        instruction = NOP_INSN;
        inst_pc     = fetch_pc;
        if (count != 2'd0) begin
            inst_valid  = 1'b1;
            instruction = fifo_word[0];
            inst_pc     = fifo_pc[0];
        end
`ifdef FETCH_BYPASS_EN
        else if (ack_live) begin
            inst_valid  = 1'b1;
            instruction = imem_rdata;
            inst_pc     = imem_addr;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            fetch_pc     <= RESET_PC;
            imem_addr    <= RESET_PC;
            count        <= '0;
            fifo_pc[0]   <= '0;
            fifo_pc[1]   <= '0;
            fifo_word[0] <= '0;
            fifo_word[1] <= '0;
        end else if (redirect) begin
            // Redirect wins over push, pop and stall; imem_addr is left alone
            // so an in-flight request stays stable until its ack is dropped.
            fetch_pc <= redirect_aligned;
            count    <= '0;
            case (state)
                WAIT:    state <= imem_ack ? IDLE : DISCARD;
                DISCARD: if (imem_ack) state <= IDLE;
                default: state <= IDLE;
            endcase
        end else begin
            count <= count_after;

            // Head always lives in slot 0. A pop shifts slot 1 down; a push
            // lands in the slot given by the post-update occupancy, which
            // also overrides the shift when both happen with one entry held.
            if (fifo_pop) begin
                fifo_pc[0]   <= fifo_pc[1];
                fifo_word[0] <= fifo_word[1];
            end
            if (push) begin
                if (count_after == 2'd2) begin
                    fifo_pc[1]   <= imem_addr;
                    fifo_word[1] <= imem_rdata;
                end else begin
                    fifo_pc[0]   <= imem_addr;
                    fifo_word[0] <= imem_rdata;
                end
            end

            case (state)
                IDLE: begin
                    if (count != 2'd2) begin
                        imem_addr <= fetch_pc;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_ack) begin
                        fetch_pc <= imem_addr + 32'd4;
                        if (count_after != 2'd2) begin
                            imem_addr <= imem_addr + 32'd4;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DISCARD: begin
                    if (imem_ack) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end that produces the 32-bit instruction word consumed by `control_unit` and the decode stage. It holds the fetch PC, issues single-outstanding read requests to instruction memory over a req/ack handshake, and buffers returned words in a 2-entry FIFO. It honours the decoder's `stall` (load second cycle) and accepts PC redirects for taken branches, JAL and JALR. While the FIFO is empty it presents a NOP so the decoder never sees stale bits.

## Interface
- `RESET_PC`, 32'h0000_0000, fetch address after reset
- `NOP_INSN`, 32'h0000_0013, word presented when empty (addi x0,x0,0)
- `clk`  in  1  clock; all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `imem_req`  out  1  read request; held until `imem_ack`
- `imem_addr`  out  32  word address; stable while `imem_req` is high
- `imem_ack`  in  1  response valid; one-cycle pulse per request
- `imem_rdata`  in  32  instruction word; valid with `imem_ack`
- `stall`  in  1  decoder holding the current instruction; no pop
- `redirect`  in  1  one-cycle pulse: discard buffered and in-flight fetches
- `redirect_pc`  in  32  new fetch PC; bits [1:0] forced to 00
- `instruction`  out  32  FIFO head, or `NOP_INSN` when empty
- `inst_pc`  out  32  PC of head; `fetch_pc` when empty
- `inst_valid`  out  1  FIFO not empty

## Operation
- State: `fetch_pc` (32b), 2-entry FIFO of {pc, word}, `count` (0..2), FSM {IDLE, WAIT, DISCARD}.
- `imem_req = (state==WAIT)|(state==DISCARD)`. `imem_addr` = address latched at request issue.
- IDLE: if `!redirect && count<2`, latch `imem_addr<=fetch_pc` and go WAIT. Otherwise stay.
- WAIT, ack, no redirect: push {`imem_addr`, `imem_rdata`} and set `fetch_pc<=imem_addr+4`. If post-update count < 2, issue the next request and stay WAIT (`imem_addr<=imem_addr+4`). Otherwise go IDLE.
- WAIT, redirect, no ack: go DISCARD. Keep `imem_req` and `imem_addr` unchanged.
- WAIT, redirect and ack in the same cycle: drop the data and go IDLE.
- DISCARD: on ack, drop the data and go IDLE. A further redirect only updates `fetch_pc`.
- Redirect in any state:
  - `fetch_pc<={redirect_pc[31:2],2'b00}`.
  - FIFO is flushed (`count<=0`).
  - Redirect takes priority over pop, push and stall.
- Pop when `inst_valid && !stall && !redirect`. Push and pop in the same cycle leave `count` unchanged.
- Addresses wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=`RESET_PC`, `fetch_pc`=`RESET_PC`.
  - `count`=0, state IDLE.
  - `inst_valid`=0, `instruction`=`NOP_INSN`, `inst_pc`=`RESET_PC`.
- First `imem_req` is high in the first cycle after the first clock edge with `rst` low.
- Latency: ack in cycle n gives `inst_valid` in cycle n+1 (default build).
- With a single-cycle-ack memory, sustained throughput is 1 instruction/cycle.
- Redirect in cycle n:
  - `inst_valid`=0 in cycle n+1.
  - Request for the new PC goes out in n+2 if no fetch was in flight. Otherwise it goes out 2 cycles after the discarded ack.
- Reset mid-transaction: all state clears immediately. A late `imem_ack` is ignored (state IDLE, no push).
- `stall` held for k cycles keeps head `instruction`/`inst_pc` constant for k cycles. Fetch continues until the FIFO is full.

## Configuration
- `FETCH_BYPASS_EN` defined:
  - When the FIFO is empty and WAIT receives an ack with no redirect, `imem_rdata` and `imem_addr` drive `instruction`/`inst_pc` combinationally, with `inst_valid`=1 in the ack cycle.
  - If `!stall`, the word is consumed and not pushed. If `stall`, it is pushed as normal.
  - Latency: 0 cycles.
- Undefined: no combinational path from `imem_rdata` to outputs; latency is 1 cycle.

## Test plan
- Reset release with `RESET_PC`=0 and single-cycle-ack memory returning word=addr -> requests 0,4,8,… on consecutive cycles; `instruction` = 0,4,8,… from cycle 2; `inst_valid` stays high.
- `stall` held 3 cycles with head pc=8 -> `instruction`=8 for 3 cycles; `count` reaches 2; `imem_req` drops; next pop yields pc 12.
- `redirect` to 32'h0000_0103 while WAIT at addr 0x10 with 2-cycle-late ack -> ack data dropped; next `imem_addr`=0x100; first valid `inst_pc`=0x100.
- `redirect` and `imem_ack` same cycle -> no push; `inst_valid`=0 next cycle; new request to redirect target.
- `RESET_PC`=32'hFFFF_FFF8 -> fetches FFFF_FFF8, FFFF_FFFC, 0000_0000 in order.
- `rst` pulsed while WAIT, ack arrives a cycle later -> no `inst_valid`; first post-reset request is to `RESET_PC`; with `FETCH_BYPASS_EN`, first `inst_valid` coincides with the ack cycle.
